// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32 frame checker: recomputes the CRC over a word-wide frame, forwards the
// payload with m_last moved onto the final payload word, and reports per-frame status.
module crc32_frame_checker #(
    parameter int unsigned MAX_WORDS   = 256,
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic             m_valid,
    output logic [31:0]      m_data,
    output logic             m_last,
    output logic             m_err,
    output logic             res_valid,
    output logic             res_ok,
    output logic [2:0]       res_status,
    output logic [31:0]      res_crc,
    output logic [LEN_W-1:0] res_len
);

    localparam logic [31:0]      POLY     = 32'h04C11DB7;
    localparam logic [31:0]      CRC_INIT = 32'hFFFFFFFF;
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_WORDS);
    localparam bit               TMO_EN   = (TIMEOUT_CYC != 0);
    localparam int unsigned      GAP_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        DROP = 2'd2
    } state_t;

    // Same 32-bit parallel update as the transmitter: s_data[31] is the first serial bit.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? POLY : 32'h0);
        end
        return r;
    endfunction

    state_t           state, state_nxt;
    logic [31:0]      crc, crc_nxt;
    logic [31:0]      hold, hold_nxt;
    logic [LEN_W-1:0] len, len_nxt;
    logic [GAP_W-1:0] gap, gap_nxt;

    logic             m_valid_nxt, m_last_nxt, m_err_nxt;
    logic [31:0]      m_data_nxt;
    logic             res_valid_nxt;
    logic [2:0]       res_status_nxt;
    logic [31:0]      res_crc_nxt;
    logic [LEN_W-1:0] res_len_nxt;

    logic timeout_hit;
    logic word_in;
    logic crc_in;

    assign word_in     = s_valid && !s_last;
    assign crc_in      = s_valid && s_last;
    assign timeout_hit = TMO_EN && (state != IDLE) && !s_valid && (gap == GAP_LAST);

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            crc        <= '0;
            hold       <= '0;
            len        <= '0;
            gap        <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            m_err      <= 1'b0;
            res_valid  <= 1'b0;
            res_ok     <= 1'b0;
            res_status <= '0;
            res_crc    <= '0;
            res_len    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_nxt;
            crc        <= crc_nxt;
            hold       <= hold_nxt;
            len        <= len_nxt;
            gap        <= gap_nxt;
            m_valid    <= m_valid_nxt;
            m_data     <= m_data_nxt;
            m_last     <= m_last_nxt;
            m_err      <= m_err_nxt;
            res_valid  <= res_valid_nxt;
            res_ok     <= res_valid_nxt && (res_status_nxt == 3'b000);
            res_status <= res_status_nxt;
            res_crc    <= res_crc_nxt;
            res_len    <= res_len_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_nxt unassigned (latch).
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (word_in) state_nxt = BODY;
            end
            BODY: begin
                if (crc_in) begin
                    state_nxt = IDLE;
                end else if (word_in) begin
                    if (len == MAX_LEN) state_nxt = DROP;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                if (crc_in || timeout_hit) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        crc_nxt        = crc;
        hold_nxt       = hold;
        len_nxt        = len;
        gap_nxt        = (s_valid || state == IDLE || timeout_hit) ? '0 : gap + 1'b1;
        m_valid_nxt    = 1'b0;
        m_data_nxt     = '0;
        m_last_nxt     = 1'b0;
        m_err_nxt      = 1'b0;
        res_valid_nxt  = 1'b0;
        res_status_nxt = '0;
        res_crc_nxt    = '0;
        res_len_nxt    = '0;

        unique case (state)
            IDLE: begin
                if (word_in) begin
                    crc_nxt  = crc_step(CRC_INIT, s_data);
                    hold_nxt = s_data;
                    len_nxt  = LEN_W'(1);
                end else if (crc_in) begin
                    // Runt: a CRC word with no payload before it.
                    res_valid_nxt  = 1'b1;
                    res_status_nxt = 3'b010;
                    res_crc_nxt    = CRC_INIT;
                end
            end
            BODY: begin
                if (crc_in) begin
                    m_valid_nxt    = 1'b1;
                    m_data_nxt     = hold;
                    m_last_nxt     = 1'b1;
                    res_valid_nxt  = 1'b1;
                    res_status_nxt = {2'b00, crc != s_data};
                    res_crc_nxt    = crc;
                    res_len_nxt    = len;
                end else if (word_in) begin
                    m_valid_nxt = 1'b1;
                    m_data_nxt  = hold;
                    if (len == MAX_LEN) begin
                        // Overflow: close the forwarded frame now; the extra word is never CRCed.
                        m_last_nxt = 1'b1;
                        m_err_nxt  = 1'b1;
                    end else begin
                        crc_nxt  = crc_step(crc, s_data);
                        hold_nxt = s_data;
                        len_nxt  = len + 1'b1;
                    end
                end else if (timeout_hit) begin
                    m_valid_nxt    = 1'b1;
                    m_data_nxt     = hold;
                    m_last_nxt     = 1'b1;
                    m_err_nxt      = 1'b1;
                    res_valid_nxt  = 1'b1;
                    res_status_nxt = 3'b100;
                    res_crc_nxt    = crc;
                    res_len_nxt    = len;
                end
            end
            DROP: begin
                if (crc_in) begin
                    res_valid_nxt  = 1'b1;
                    res_status_nxt = {2'b01, crc != s_data};
                    res_crc_nxt    = crc;
                    res_len_nxt    = MAX_LEN;
                end else if (timeout_hit) begin
                    res_valid_nxt  = 1'b1;
                    res_status_nxt = 3'b110;
                    res_crc_nxt    = crc;
                    res_len_nxt    = MAX_LEN;
                end
            end
            default: ;
        endcase
    end

endmodule
